// File: rtl/rou_wsched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rou_wsched_pkg
// Description : Shared types and helpers for the roubus write-burst scheduler.
//               State encoding, bus beat width, and the byte-strobe helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rou_wsched_pkg;

    localparam int BEAT_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        BEAT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Strobe covering `need` consecutive lanes starting at lane `off`.
    // The mask is built on 17 bits so that need==16 yields all ones.
    function automatic logic [15:0] strb_mask(input logic [4:0] need,
                                              input logic [3:0] off);
        logic [16:0] m;
        m = (17'd1 << need) - 17'd1;
        return m[15:0] << off;
    endfunction

endpackage : rou_wsched_pkg
`default_nettype wire

// File: rtl/rou_wsched_beatcalc.sv
`default_nettype none
// ============================================================================
// Module      : rou_wsched_beatcalc
// Description : Combinational per-beat calculator. From the bytes remaining
//               and the current lane offset it derives the byte count of the
//               beat, its strobe and whether it is the final beat.
// Ports       : i_rem   - bytes still to send
//               i_off   - lane offset of the current beat
//               o_need  - bytes carried by this beat, min(16-off, rem)
//               o_wstrb - byte strobes for this beat
//               o_wlast - this beat finishes the command
// Revision    : 1.0 - initial release
// ============================================================================
module rou_wsched_beatcalc
    import rou_wsched_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic [LEN_W-1:0] i_rem,
    input  logic [3:0]       i_off,
    output logic [4:0]       o_need,
    output logic [15:0]      o_wstrb,
    output logic             o_wlast
);

    logic [4:0] w_room;

    always_comb begin
        w_room = 5'(BEAT_BYTES) - {1'b0, i_off};
        if (i_rem >= LEN_W'(w_room)) begin
            o_need = w_room;
        end else begin
            o_need = i_rem[4:0];
        end
        o_wstrb = strb_mask(o_need, i_off);
        o_wlast = (i_rem == LEN_W'(o_need));
    end

endmodule : rou_wsched_beatcalc
`default_nettype wire

// File: rtl/rou_wburst_sched.sv
`default_nettype none
// ============================================================================
// Module      : rou_wburst_sched
// Description : Write-burst scheduler for the roubus byte-align buffer.
//               Takes one write command (byte address, byte length), waits
//               for the align buffer to hold enough bytes for each beat and
//               emits 16-byte aligned write beats with strobes and wlast,
//               popping the buffer on every accepted beat.
// Ports       : cmd_*        - command handshake, address and length
//               buf_*        - align buffer status/data in, read controls out
//               w*           - write-data channel beat
//               done / busy  - completion pulse / not-idle status
//               timeout_err  - sticky WAIT watchdog error (optional)
// Options     : ROU_WSCHED_TIMEOUT_EN - enables the WAIT watchdog, the
//               buf_softreset flush pulse and the timeout_err port.
// Revision    : 1.0 - initial release
// ============================================================================
module rou_wburst_sched
    import rou_wsched_pkg::*;
#(
    parameter int LEN_W     = 16,
    parameter int ADDR_W    = 32,
    parameter int TO_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [4:0]        buf_ovalids,
    input  logic [127:0]      buf_oline,
    output logic              buf_reading,
    output logic [4:0]        buf_reading_bytes,
    output logic [3:0]        buf_wstrb_offset,
    output logic              buf_softreset,
    output logic              wvalid,
    input  logic              wready,
    output logic [ADDR_W-1:0] waddr,
    output logic [127:0]      wdata,
    output logic [15:0]       wstrb,
    output logic              wlast,
    output logic              done,
`ifdef ROU_WSCHED_TIMEOUT_EN
    output logic              timeout_err,
`endif
    output logic              busy
);

    state_t            r_state_q, w_state_d;
    logic [LEN_W-1:0]  r_rem_q,   w_rem_d;
    logic [3:0]        r_off_q,   w_off_d;
    logic [ADDR_W-1:0] r_baddr_q, w_baddr_d;

    logic [4:0]        w_need;
    logic [15:0]       w_strb;
    logic              w_last;

    rou_wsched_beatcalc #(
        .LEN_W (LEN_W)
    ) u_beatcalc (
        .i_rem   (r_rem_q),
        .i_off   (r_off_q),
        .o_need  (w_need),
        .o_wstrb (w_strb),
        .o_wlast (w_last)
    );

`ifdef ROU_WSCHED_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TO_CYCLES + 1);
    logic [c_CNT_W-1:0] r_cnt_q, w_cnt_d;
    logic               r_tofire_q, w_tofire_d;
    logic               r_terr_q, w_terr_d;
`else
    logic w_unused_to;
    assign w_unused_to = (TO_CYCLES != 0);
`endif

    always_comb begin
        w_state_d         = r_state_q;
        w_rem_d           = r_rem_q;
        w_off_d           = r_off_q;
        w_baddr_d         = r_baddr_q;
        cmd_ready         = 1'b0;
        wvalid            = 1'b0;
        waddr             = '0;
        wstrb             = '0;
        wlast             = 1'b0;
        buf_reading       = 1'b0;
        buf_reading_bytes = '0;
        buf_wstrb_offset  = '0;
        done              = 1'b0;
`ifdef ROU_WSCHED_TIMEOUT_EN
        w_cnt_d           = r_cnt_q;
        w_tofire_d        = 1'b0;
        w_terr_d          = r_terr_q;
`endif
        case (r_state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_rem_d   = cmd_len;
                    w_off_d   = cmd_addr[3:0];
                    w_baddr_d = {cmd_addr[ADDR_W-1:4], 4'b0000};
                    w_state_d = (cmd_len == '0) ? DONE : WAIT;
`ifdef ROU_WSCHED_TIMEOUT_EN
                    w_cnt_d   = '0;
                    w_terr_d  = 1'b0;
`endif
                end
            end
            WAIT: begin
                // The buffer's output line is shifted by this offset, so keep
                // it steady while the buffer fills.
                buf_wstrb_offset = r_off_q;
                if (buf_ovalids >= w_need) begin
                    w_state_d = BEAT;
                end
`ifdef ROU_WSCHED_TIMEOUT_EN
                else if (r_cnt_q == c_CNT_W'(TO_CYCLES - 1)) begin
                    w_state_d  = DONE;
                    w_tofire_d = 1'b1;
                    w_terr_d   = 1'b1;
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
`endif
            end
            BEAT: begin
                wvalid           = 1'b1;
                waddr            = r_baddr_q;
                wstrb            = w_strb;
                wlast            = w_last;
                buf_wstrb_offset = r_off_q;
                if (wready) begin
                    buf_reading       = 1'b1;
                    buf_reading_bytes = w_need;
                    w_rem_d           = r_rem_q - LEN_W'(w_need);
                    w_off_d           = 4'd0;
                    w_baddr_d         = r_baddr_q + ADDR_W'(BEAT_BYTES);
                    w_state_d         = w_last ? DONE : WAIT;
`ifdef ROU_WSCHED_TIMEOUT_EN
                    w_cnt_d           = '0;
`endif
                end
            end
            DONE: begin
                done      = 1'b1;
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // Unused lanes are forced to zero so downstream never sees stale bytes.
    for (genvar i = 0; i < BEAT_BYTES; i++) begin : g_lane
        assign wdata[8*i +: 8] = buf_oline[8*i +: 8] & {8{wstrb[i]}};
    end

    assign busy = (r_state_q != IDLE);

`ifdef ROU_WSCHED_TIMEOUT_EN
    assign buf_softreset = r_tofire_q;
    assign timeout_err   = r_terr_q;
`else
    assign buf_softreset = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= IDLE;
            r_rem_q    <= '0;
            r_off_q    <= '0;
            r_baddr_q  <= '0;
`ifdef ROU_WSCHED_TIMEOUT_EN
            r_cnt_q    <= '0;
            r_tofire_q <= 1'b0;
            r_terr_q   <= 1'b0;
`endif
        end else begin
            r_state_q  <= w_state_d;
            r_rem_q    <= w_rem_d;
            r_off_q    <= w_off_d;
            r_baddr_q  <= w_baddr_d;
`ifdef ROU_WSCHED_TIMEOUT_EN
            r_cnt_q    <= w_cnt_d;
            r_tofire_q <= w_tofire_d;
            r_terr_q   <= w_terr_d;
`endif
        end
    end

endmodule : rou_wburst_sched
`default_nettype wire
